// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target block: FSM
//               state encoding, command codes, bus-idle level and the
//               address-match rule.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX_BYTE  = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX_BYTE  = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CMD_START   = 3'd0,
        CMD_RESTART = 3'd1,
        CMD_STOP    = 3'd2,
        CMD_RD      = 3'd3,
        CMD_WR      = 3'd4
    } cmd_t;

    // Level of both bus lines when nobody drives them (pull-ups).
    localparam logic c_bus_idle = 1'b1;

    // Address byte matches our target address; general call (0) never matches.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (own_addr != 7'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_edge_sync
// Description : Two-flop synchronizers for raw SCL/SDA followed by one
//               history register, producing SCL edge strobes and START/STOP
//               conditions (3 clk behind the bus).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_edge_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;

    // Synchronize both lines and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= {c_bus_idle, c_bus_idle};
            r_sda_sync <= {c_bus_idle, c_bus_idle};
            r_scl_prev <= c_bus_idle;
            r_sda_prev <= c_bus_idle;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign scl_rise  =  r_scl_sync[1] & ~r_scl_prev;
    assign scl_fall  = ~r_scl_sync[1] &  r_scl_prev;
    // SDA may only move while SCL is high for START/STOP, so require SCL high
    // in both the current and previous sample.
    assign start_det =  r_scl_sync[1] & r_scl_prev &  r_sda_prev & ~r_sda_sync[1];
    assign stop_det  =  r_scl_sync[1] & r_scl_prev & ~r_sda_prev &  r_sda_sync[1];
    assign sda_sync  =  r_sda_sync[1];

endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target with 7-bit address. Write bytes are presented on
//               rx_data/rx_valid; read bytes are requested with tx_req and
//               latched from tx_data one clk later. No clock stretching.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       addressed
);

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_sda;
    logic [7:0] w_byte;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_rw;
    logic       r_acked;
    logic       r_tx_load;

    i2c_edge_sync u_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_sync  (w_sda)
    );

    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte = {r_shift[6:0], w_sda};

    // Protocol FSM; START/STOP take priority over whatever state we are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_rw      <= 1'b0;
            r_acked   <= 1'b0;
            r_tx_load <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            r_tx_load <= 1'b0;
            if (w_start) begin
                r_state   <= ST_ADDR;
                r_shift   <= 8'h00;
                r_bitcnt  <= 3'd0;
                r_acked   <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
                addressed <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bitcnt  <= 3'd0;
                r_acked   <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                addressed <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (addr_match(w_byte, ADDR)) begin
                                    r_state   <= ST_ADDR_ACK;
                                    addressed <= 1'b1;
                                    r_rw      <= w_byte[0];
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK low, the next one ends it.
                    ST_ADDR_ACK, ST_RX_ACK: begin
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe   <= 1'b0;
                                r_bitcnt <= 3'd0;
                                if (r_rw) begin
                                    r_state   <= ST_TX_BYTE;
                                    tx_req    <= 1'b1;
                                    r_tx_load <= 1'b1;
                                end else begin
                                    r_state <= ST_RX_BYTE;
                                end
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                rx_data  <= w_byte;
                                rx_valid <= 1'b1;
                                r_state  <= ST_RX_ACK;
                            end
                        end
                    end
                    // MSB goes out as soon as the byte is latched; each later
                    // SCL fall shifts out the next bit, the 8th hands over.
                    ST_TX_BYTE: begin
                        if (r_tx_load) begin
                            r_shift <= {tx_data[6:0], 1'b0};
                            sda_oe  <= ~tx_data[7];
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 3'd7) begin
                                sda_oe   <= 1'b0;
                                r_bitcnt <= 3'd0;
                                r_acked  <= 1'b0;
                                r_state  <= ST_TX_ACK;
                            end else begin
                                sda_oe   <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= ST_IGNORE;
                            end else begin
                                r_acked <= 1'b1;
                            end
                        end else if (w_scl_fall && r_acked) begin
                            r_state   <= ST_TX_BYTE;
                            r_acked   <= 1'b0;
                            tx_req    <= 1'b1;
                            r_tx_load <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bus-level bench for i2c_slave: a bit-banged master drives the
//               wired-AND bus and results are compared to a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int         T   = 8;
    localparam logic [6:0] SLV = 7'h42;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       addressed;

    int total = 0;
    int bad   = 0;

    int         rxv_cnt = 0;
    int         txr_cnt = 0;
    int         oe_cnt  = 0;
    int         oe_viol = 0;
    logic [7:0] rx_seen = 8'h00;
    logic       oe_prev = 1'b0;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave #(.ADDR(SLV)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .busy      (busy),
        .addressed (addressed)
    );

    always #5 clk = ~clk;

    // Pulse counters and the "SDA only moves while SCL is low" observer.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rx_seen <= rx_data;
        end
        if (tx_req) txr_cnt <= txr_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (!reset && (sda_oe !== oe_prev) && scl_m) oe_viol <= oe_viol + 1;
        oe_prev <= sda_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic model_ack(input logic [7:0] a);
        return (a[7:1] == SLV) && (a[7:1] != 7'd0);
    endfunction

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b;
        wclk(T);
        scl_m = 1'b1;
        wclk(T);
        seen  = sda_i;
        scl_m = 1'b0;
        wclk(T);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wclk(T);
        scl_m = 1'b1;
        wclk(T);
        sda_m = 1'b0;
        wclk(T);
        scl_m = 1'b0;
        wclk(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wclk(T);
        scl_m = 1'b1;
        wclk(T);
        sda_m = 1'b1;
        wclk(T);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        tx_data = next_tx;
        clock_bit(nack, s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wclk(4);
        reset = 1'b0;
        wclk(2);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req got=%b want=0", tx_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (addressed !== 1'b0) begin bad++; $display("FAIL reset_addressed got=%b want=0", addressed); end
    endtask

    task automatic test_write_basic();
        logic ack;
        int   r0;
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_addr_ack got=%b want=1", ack); end
        total++; if (addressed !== 1'b1) begin bad++; $display("FAIL wr_addressed got=%b want=1", addressed); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
        send_byte(8'hA5, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_data_ack got=%b want=1", ack); end
        total++; if (rxv_cnt - r0 !== 1) begin bad++; $display("FAIL wr_rx_valid_cnt got=%0d want=1", rxv_cnt - r0); end
        total++; if (rx_seen !== 8'hA5) begin bad++; $display("FAIL wr_rx_data got=%h want=a5", rx_seen); end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b want=0", busy); end
        total++; if (addressed !== 1'b0) begin bad++; $display("FAIL wr_addressed_after_stop got=%b want=0", addressed); end
    endtask

    task automatic test_nomatch();
        logic ack;
        int   o0;
        int   r0;
        o0 = oe_cnt;
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h86, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL nm_addr_ack got=%b want=0", ack); end
        total++; if (addressed !== 1'b0) begin bad++; $display("FAIL nm_addressed got=%b want=0", addressed); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nm_busy got=%b want=1", busy); end
        send_byte(8'($urandom), ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL nm_data_ack got=%b want=0", ack); end
        i2c_stop();
        total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL nm_sda_oe_cycles got=%0d want=0", oe_cnt - o0); end
        total++; if (rxv_cnt - r0 !== 0) begin bad++; $display("FAIL nm_rx_valid_cnt got=%0d want=0", rxv_cnt - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nm_busy_after_stop got=%b want=0", busy); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] b;
        int         t0;
        t0 = txr_cnt;
        tx_data = 8'h3C;
        i2c_start();
        send_byte(8'h85, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_ack got=%b want=1", ack); end
        recv_byte(1'b1, 8'h00, b);
        total++; if (b !== 8'h3C) begin bad++; $display("FAIL rd_byte got=%h want=3c", b); end
        total++; if (txr_cnt - t0 !== 1) begin bad++; $display("FAIL rd_tx_req_cnt got=%0d want=1", txr_cnt - t0); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rd_released_after_nack got=%b want=0", sda_oe); end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_stop got=%b want=0", busy); end
    endtask

    task automatic test_restart();
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         r0;
        r0 = rxv_cnt;
        d  = 8'($urandom);
        i2c_start();
        send_byte(8'h84, ack);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
        i2c_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%b want=1", busy); end
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rs_addr_ack got=%b want=1", ack); end
        total++; if (rxv_cnt - r0 !== 0) begin bad++; $display("FAIL rs_no_rx_valid got=%0d want=0", rxv_cnt - r0); end
        send_byte(d, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rs_data_ack got=%b want=1", ack); end
        total++; if (rx_seen !== d) begin bad++; $display("FAIL rs_rx_data got=%h want=%h", rx_seen, d); end
        i2c_stop();
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         r0;
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'h85, ack);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rm_driving_bit3 got=%b want=1", sda_oe); end
        reset = 1'b1;
        wclk(1);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_sda_oe got=%b want=0", sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
        total++; if (addressed !== 1'b0) begin bad++; $display("FAIL rm_addressed got=%b want=0", addressed); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rm_rx_data got=%h want=00", rx_data); end
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL rm_tx_req got=%b want=0", tx_req); end
        wclk(2);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wclk(4 * T);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_no_resume got=%b want=0", busy); end
        d  = 8'($urandom);
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rm_addr_ack got=%b want=1", ack); end
        send_byte(d, ack);
        total++; if (rxv_cnt - r0 !== 1) begin bad++; $display("FAIL rm_rx_valid_cnt got=%0d want=1", rxv_cnt - r0); end
        total++; if (rx_seen !== d) begin bad++; $display("FAIL rm_rx_data got=%h want=%h", rx_seen, d); end
        i2c_stop();
    endtask

    task automatic test_stop_mid();
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         r0;
        d  = 8'($urandom);
        r0 = rxv_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(d, ack);
        for (int i = 0; i < 3; i++) clock_bit(1'($urandom), s);
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sm_busy got=%b want=0", busy); end
        total++; if (rx_data !== d) begin bad++; $display("FAIL sm_rx_data got=%h want=%h", rx_data, d); end
        total++; if (rxv_cnt - r0 !== 1) begin bad++; $display("FAIL sm_rx_valid_cnt got=%0d want=1", rxv_cnt - r0); end
    endtask

    task automatic test_random();
        logic [6:0] a7;
        logic [7:0] abyte;
        logic [7:0] bytes [3];
        logic [7:0] got;
        logic [7:0] want;
        logic       rw;
        logic       ack;
        logic       m;
        int         nb;
        int         r0;
        int         t0;
        for (int n = 0; n < 10; n++) begin
            a7    = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
            rw    = 1'($urandom);
            nb    = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom);
            abyte = {a7, rw};
            m     = model_ack(abyte);
            r0    = rxv_cnt;
            t0    = txr_cnt;
            tx_data = bytes[0];
            i2c_start();
            send_byte(abyte, ack);
            total++; if (ack !== m) begin bad++; $display("FAIL rnd_addr_ack addr=%h got=%b want=%b", abyte, ack, m); end
            if (!rw) begin
                for (int k = 0; k < nb; k++) begin
                    send_byte(bytes[k], ack);
                    total++; if (ack !== m) begin bad++; $display("FAIL rnd_wr_ack byte=%0d got=%b want=%b", k, ack, m); end
                end
                total++; if (rxv_cnt - r0 !== (m ? nb : 0)) begin bad++; $display("FAIL rnd_rx_valid_cnt got=%0d want=%0d", rxv_cnt - r0, m ? nb : 0); end
                if (m) begin
                    total++; if (rx_seen !== bytes[nb-1]) begin bad++; $display("FAIL rnd_rx_data got=%h want=%h", rx_seen, bytes[nb-1]); end
                end
            end else begin
                for (int k = 0; k < nb; k++) begin
                    recv_byte(k == nb - 1, (k < 2) ? bytes[k+1] : 8'h00, got);
                    want = m ? bytes[k] : 8'hFF;
                    total++; if (got !== want) begin bad++; $display("FAIL rnd_rd_byte byte=%0d got=%h want=%h", k, got, want); end
                end
                total++; if (txr_cnt - t0 !== (m ? nb : 0)) begin bad++; $display("FAIL rnd_tx_req_cnt got=%0d want=%0d", txr_cnt - t0, m ? nb : 0); end
            end
            i2c_stop();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_after_stop got=%b want=0", busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_nomatch();
        test_read();
        test_restart();
        test_reset_mid();
        test_stop_mid();
        test_random();
        total++; if (oe_viol !== 0) begin bad++; $display("FAIL sda_oe_moved_while_scl_high got=%0d want=0", oe_viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL provide parameter ADDR, default 7'h42, meaning its own 7-bit target address.
REQ-002 The block SHALL provide port clk, input, 1 bit: the system clock, the only clock in the block.
REQ-003 The block SHALL provide port reset, input, 1 bit: reset, synchronous to clk and active-high.
REQ-004 The block SHALL provide port scl_i, input, 1 bit: raw bus SCL, asynchronous to clk.
REQ-005 The block SHALL provide port sda_i, input, 1 bit: raw bus SDA, asynchronous to clk.
REQ-006 The block SHALL provide port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases SDA (open-drain).
REQ-007 The block SHALL provide port rx_data, output, 8 bits: the last byte written by the master.
REQ-008 The block SHALL provide port rx_valid, output, 1 bit: a one-clk pulse marking that rx_data is new.
REQ-009 The block SHALL provide port tx_req, output, 1 bit: a one-clk pulse requesting the next read byte.
REQ-010 The block SHALL provide port tx_data, input, 8 bits: the read byte, latched on the clk edge after tx_req.
REQ-011 The block SHALL provide port busy, output, 1 bit: high from START to STOP, or until the transfer is abandoned.
REQ-012 The block SHALL provide port addressed, output, 1 bit: high while the current transaction matched ADDR.

Function
REQ-013 scl_i and sda_i SHALL each pass a 2-flop synchronizer followed by one edge-detect register, so detected events lag the bus by 3 clk.
REQ-014 A START SHALL be detected when SDA falls while SCL is high.
REQ-015 A STOP SHALL be detected when SDA rises while SCL is high.
REQ-016 START or STOP SHALL override every state, including mid-byte and mid-ACK.
REQ-017 The FSM SHALL have these states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE.
REQ-018 IDLE -> ADDR on START; any state -> ADDR on a repeated START; any state -> IDLE on STOP.
REQ-019 Data SHALL be sampled on SCL rising edges, MSB first, using an 8-bit shift register and a 3-bit bit counter.
REQ-020 sda_oe SHALL change only on SCL falling edges.
REQ-021 ADDR: after 8 bits, if bits[7:1]==ADDR the FSM SHALL go to ADDR_ACK, set addressed=1 and drive sda_oe=1 for one SCL period; otherwise it SHALL go to IGNORE with sda_oe=0.
REQ-022 After ADDR_ACK, the FSM SHALL go to RX_BYTE if the R/W bit is 0, or to TX_BYTE if it is 1.
REQ-023 RX_BYTE: on the 8th rising edge, rx_data SHALL update and rx_valid SHALL pulse once; then RX_ACK drives sda_oe=1 for one SCL period and returns to RX_BYTE.
REQ-024 TX_BYTE: tx_req SHALL pulse on the SCL falling edge that ends ADDR_ACK or TX_ACK; the latched byte SHALL be driven as sda_oe = ~bit, MSB first.
REQ-025 TX_ACK: sda_oe SHALL be 0, and the master's bit SHALL be sampled on the SCL rising edge.
REQ-026 In TX_ACK, ACK (0) SHALL lead to TX_BYTE and NACK (1) SHALL lead to IGNORE.
REQ-027 IGNORE SHALL keep sda_oe=0 and leave only on START or STOP.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 addressed SHALL clear on STOP or START.
REQ-030 No clock stretching SHALL be performed, and general-call address 0 SHALL NOT be matched.

Reset
REQ-031 On reset, the FSM SHALL enter IDLE and outputs SHALL be: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, addressed=0.
REQ-032 On reset, the shift register and bit counter SHALL clear, and the synchronizers SHALL load 1 (idle bus).
REQ-033 Reset asserted mid-transfer SHALL release SDA on the first clk edge with reset high.
REQ-034 After reset, the block SHALL wait for a fresh START; it SHALL NOT resume the interrupted transfer.

Structure
REQ-035 Shared package i2c_pkg SHALL hold the FSM state encoding, the command codes (START=0, RESTART=1, STOP=2, RD=3, WR=4) and the bus-idle constant.
REQ-036 A sub-module i2c_edge_sync SHALL implement synchronization and edge detection, with outputs scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-037 Bench: START, address 0x84 (0x42 + W), data 0xA5, STOP -> ACK on both 9th bits, rx_valid pulses once with rx_data=0xA5, busy returns to 0 after STOP.
REQ-038 Bench: START, address 0x86 (0x43 + W) -> sda_oe stays 0 for the whole transaction, addressed=0, state IGNORE until STOP.
REQ-039 Bench: START, address 0x85 (read), tx_data=0x3C, master NACK -> SDA carries 0,0,1,1,1,1,0,0, tx_req pulses once, SDA released after NACK.
REQ-040 Bench: repeated START after the 4th data bit of a write -> returns to ADDR, bit counter 0, no rx_valid pulse.
REQ-041 Bench: reset during a read at bit 3 -> sda_oe=0 on the next clk, all outputs at reset values, next START handled normally.
REQ-042 Bench: STOP mid-byte -> IDLE, busy=0, rx_data unchanged.
